// File: rtl/lab1_tdm_demux.sv
// Receive-side 4:1 TDM demultiplexer: locks to slot-0 sync, steers slots into q, one frame_valid per frame.
// Optional TDM_PARITY_EN adds a fifth even-parity slot and the parity_err pulse.
module lab1_tdm_demux #(
    parameter int MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [3:0] q,
    output logic       frame_valid,
    output logic [2:0] sel,
    output logic       locked,
    output logic       sync_err,
    output logic       parity_err
);

`ifdef TDM_PARITY_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic [2:0]   miss_q, miss_d;
    logic [N-1:0] buf_q, buf_d, buf_wr;
    logic [3:0]   q_q, q_d;
    logic         fv_q, fv_d;
    logic         serr_q, serr_d;
    logic         perr_q, perr_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        miss_d  = miss_q;
        buf_d   = buf_q;
        q_d     = q_q;
        fv_d    = 1'b0;
        serr_d  = 1'b0;
        perr_d  = 1'b0;
        buf_wr  = buf_q;
        for (int k = 0; k < N; k++) begin
            if (sel_q == 3'(k)) buf_wr[k] = din;
        end

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        buf_d[0] = din;
                        sel_d    = 3'd1;
                        miss_d   = 3'd0;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync && sel_q != 3'd0) begin
                        // Misplaced marker: restart the frame on this bit
                        serr_d   = 1'b1;
                        buf_d[0] = din;
                        sel_d    = 3'd1;
                        miss_d   = 3'd0;
                    end else if (sel_q == 3'd0) begin
                        buf_d[0] = din;
                        if (sync) begin
                            miss_d = 3'd0;
                            sel_d  = 3'd1;
                        end else if (miss_q + 3'd1 >= 3'(MISS_MAX)) begin
                            state_d = HUNT;
                            sel_d   = 3'd0;
                            miss_d  = 3'd0;
                        end else begin
                            // Flywheel through a missing marker
                            miss_d = miss_q + 3'd1;
                            sel_d  = 3'd1;
                        end
                    end else begin
                        buf_d = buf_wr;
                        if (sel_q == 3'(N - 1)) begin
                            q_d   = buf_wr[3:0];
                            fv_d  = 1'b1;
                            sel_d = 3'd0;
`ifdef TDM_PARITY_EN
                            perr_d = ^buf_wr;
`endif
                        end else begin
                            sel_d = sel_q + 3'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            sel_q   <= 3'd0;
            miss_q  <= 3'd0;
            buf_q   <= '0;
            q_q     <= 4'd0;
            fv_q    <= 1'b0;
            serr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            miss_q  <= miss_d;
            buf_q   <= buf_d;
            q_q     <= q_d;
            fv_q    <= fv_d;
            serr_q  <= serr_d;
            perr_q  <= perr_d;
        end
    end

    assign q           = q_q;
    assign frame_valid = fv_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = serr_q;
`ifdef TDM_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_lab1_tdm_demux.sv
// Bench for lab1_tdm_demux: directed vector table plus randomized traffic against a queue-based frame model.
module tb_lab1_tdm_demux;

`ifdef TDM_PARITY_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif
    localparam int MISS_MAX = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] q;
    logic       frame_valid;
    logic [2:0] sel;
    logic       locked;
    logic       sync_err;
    logic       parity_err;

    lab1_tdm_demux #(.MISS_MAX(MISS_MAX)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .q(q), .frame_valid(frame_valid), .sel(sel), .locked(locked),
        .sync_err(sync_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: the partial frame is a queue of received bits.
    bit       m_locked;
    int       m_miss;
    bit       frame[$];
    bit [3:0] m_q;
    bit       m_fv, m_serr, m_perr;

    function automatic int m_sel();
        return m_locked ? frame.size() : 0;
    endfunction

    task automatic model(input bit r, input bit e, input bit d, input bit s);
        bit p;
        m_fv = 0; m_serr = 0; m_perr = 0;
        if (r) begin
            m_locked = 0; m_miss = 0; frame.delete(); m_q = 4'd0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin m_locked = 1; m_miss = 0; frame = {d}; end
            end else if (s && frame.size() != 0) begin
                m_serr = 1; frame = {d}; m_miss = 0;
            end else if (frame.size() == 0) begin
                if (s) begin
                    m_miss = 0; frame = {d};
                end else begin
                    m_miss++;
                    if (m_miss == MISS_MAX) begin m_locked = 0; m_miss = 0; end
                    else frame = {d};
                end
            end else begin
                frame.push_back(d);
                if (frame.size() == N) begin
                    m_q = {frame[3], frame[2], frame[1], frame[0]};
                    m_fv = 1;
                    p = 0;
                    foreach (frame[i]) p ^= frame[i];
                    m_perr = (N == 5) ? p : 1'b0;
                    frame.delete();
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit s);
        rst = r; en = e; din = d; sync = s;
        @(posedge clk);
        cyc++;
        model(r, e, d, s);
        #1;
    endtask

    task automatic chk_model();
        chk("q", q, m_q);
        chk("frame_valid", {3'b0, frame_valid}, {3'b0, m_fv});
        chk("sel", {1'b0, sel}, 4'(m_sel()));
        chk("locked", {3'b0, locked}, {3'b0, m_locked});
        chk("sync_err", {3'b0, sync_err}, {3'b0, m_serr});
        chk("parity_err", {3'b0, parity_err}, {3'b0, m_perr});
    endtask

    typedef struct {
        bit       r, e, d, s;
        bit [3:0] xq;
        bit       xfv;
        bit [2:0] xsel;
        bit       xlk, xse;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int slot;
        bit s;

`ifndef TDM_PARITY_EN
        //         r  e  d  s   q      fv sel lk se
        tbl = '{
            '{1, 0, 0, 0, 4'h0, 0, 0, 0, 0},
            // lock and steer: 1,0,0,0 then 0,1,1,0
            '{0, 1, 1, 1, 4'h0, 0, 1, 1, 0}, '{0, 1, 0, 0, 4'h0, 0, 2, 1, 0},
            '{0, 1, 0, 0, 4'h0, 0, 3, 1, 0}, '{0, 1, 0, 0, 4'h1, 1, 0, 1, 0},
            '{0, 1, 0, 1, 4'h1, 0, 1, 1, 0}, '{0, 1, 1, 0, 4'h1, 0, 2, 1, 0},
            '{0, 1, 1, 0, 4'h1, 0, 3, 1, 0}, '{0, 1, 0, 0, 4'h6, 1, 0, 1, 0},
            // en gating: 1,1,0,1 with idle cycles between slots
            '{0, 1, 1, 1, 4'h6, 0, 1, 1, 0}, '{0, 0, 0, 1, 4'h6, 0, 1, 1, 0},
            '{0, 1, 1, 0, 4'h6, 0, 2, 1, 0}, '{0, 0, 1, 0, 4'h6, 0, 2, 1, 0},
            '{0, 1, 0, 0, 4'h6, 0, 3, 1, 0}, '{0, 0, 0, 0, 4'h6, 0, 3, 1, 0},
            '{0, 1, 1, 0, 4'hb, 1, 0, 1, 0}, '{0, 0, 0, 0, 4'hb, 0, 0, 1, 0},
            // misplaced sync at sel=2
            '{0, 1, 0, 1, 4'hb, 0, 1, 1, 0}, '{0, 1, 1, 0, 4'hb, 0, 2, 1, 0},
            '{0, 1, 1, 1, 4'hb, 0, 1, 1, 1}, '{0, 1, 0, 0, 4'hb, 0, 2, 1, 0},
            '{0, 1, 1, 0, 4'hb, 0, 3, 1, 0}, '{0, 1, 1, 0, 4'hd, 1, 0, 1, 0},
            // two missing syncs: first frame delivered, then lock drops
            '{0, 1, 0, 0, 4'hd, 0, 1, 1, 0}, '{0, 1, 0, 0, 4'hd, 0, 2, 1, 0},
            '{0, 1, 1, 0, 4'hd, 0, 3, 1, 0}, '{0, 1, 0, 0, 4'h4, 1, 0, 1, 0},
            '{0, 1, 1, 0, 4'h4, 0, 0, 0, 0}, '{0, 1, 1, 0, 4'h4, 0, 0, 0, 0},
            '{0, 1, 0, 0, 4'h4, 0, 0, 0, 0},
            // relock, then reset at sel=2, then relock cleanly
            '{0, 1, 1, 1, 4'h4, 0, 1, 1, 0}, '{0, 1, 1, 0, 4'h4, 0, 2, 1, 0},
            '{1, 1, 1, 0, 4'h0, 0, 0, 0, 0},
            '{0, 1, 1, 1, 4'h0, 0, 1, 1, 0}, '{0, 1, 0, 0, 4'h0, 0, 2, 1, 0},
            '{0, 1, 1, 0, 4'h0, 0, 3, 1, 0}, '{0, 1, 1, 0, 4'hd, 1, 0, 1, 0},
            '{0, 0, 0, 0, 4'hd, 0, 0, 1, 0}
        };
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].s);
            chk("tbl_q", q, tbl[i].xq);
            chk("tbl_frame_valid", {3'b0, frame_valid}, {3'b0, tbl[i].xfv});
            chk("tbl_sel", {1'b0, sel}, {1'b0, tbl[i].xsel});
            chk("tbl_locked", {3'b0, locked}, {3'b0, tbl[i].xlk});
            chk("tbl_sync_err", {3'b0, sync_err}, {3'b0, tbl[i].xse});
            chk("tbl_parity_err", {3'b0, parity_err}, 4'h0);
        end
`else
        // Parity frames: 1,1,0,1 with good parity 1, then bad parity 0
        step(1, 0, 0, 0);
        chk("rst_q", q, 4'h0);
        chk("rst_locked", {3'b0, locked}, 4'h0);
        step(0, 1, 1, 1); step(0, 1, 1, 0); step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("par_sel4", {1'b0, sel}, 4'h4);
        step(0, 1, 1, 0);
        chk("par_q", q, 4'hb);
        chk("par_fv", {3'b0, frame_valid}, 4'h1);
        chk("par_ok", {3'b0, parity_err}, 4'h0);
        step(0, 1, 1, 1); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("par_bad_q", q, 4'hb);
        chk("par_bad_fv", {3'b0, frame_valid}, 4'h1);
        chk("par_bad_err", {3'b0, parity_err}, 4'h1);
        step(0, 0, 0, 0);
        chk("par_err_pulse", {3'b0, parity_err}, 4'h0);
`endif

        // Randomized traffic from a transmitter that mostly places sync correctly
        step(1, 0, 0, 0);
        chk_model();
        slot = 0;
        for (int i = 0; i < 3000; i++) begin
            bit e, r;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) != 0);
            if (slot == 0) s = ($urandom_range(0, 9) != 0);
            else           s = ($urandom_range(0, 29) == 0);
            step(r, e, 1'($urandom), s);
            chk_model();
            if (e) slot = (slot + 1) % N;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lab1_tdm_demux.md
# lab1_tdm_demux

Receive-side time-division demultiplexer for the lab's 4:1 serial channel. A transmitter drives one channel per slot onto a single wire with a frame-sync marker on slot 0. This block locks to that marker, steers each slot's bit into its own output register, and presents the four channel bits in parallel once per frame with a one-cycle valid strobe. It sits directly after the serial link and feeds the lab's display and checking logic.

## Interface
Parameters:
- `MISS_MAX`, default 2: number of consecutive expected-sync slots without `sync` before lock is dropped; legal range 1..7.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: slot strobe; `din` and `sync` are sampled only on edges where `en=1`.
- `din` input, 1 bit: serial slot data.
- `sync` input, 1 bit: frame marker, asserted with the slot-0 bit.
- `q` output, 4 bits: last complete frame; `q[k]` holds slot k.
- `frame_valid` output, 1 bit: one-cycle pulse when `q` updates.
- `sel` output, 3 bits: index of the slot expected at the next `en`.
- `locked` output, 1 bit: high in LOCKED state.
- `sync_err` output, 1 bit: one-cycle pulse on a misplaced sync.
- `parity_err` output, 1 bit: one-cycle pulse, used only with `TDM_PARITY_EN` and tied to 0 otherwise.

## Operation
- Reset values:
  - outputs: `q=0`, `frame_valid=0`, `sel=0`, `locked=0`, `sync_err=0`, `parity_err=0`
  - internal: state HUNT, miss counter 0, shift buffer 0.
- The frame length is N slots: N=4, or N=5 with `TDM_PARITY_EN`. The last slot is N-1.
- HUNT state:
  - All `en` cycles are ignored until `en=1 && sync=1`.
  - That bit is stored as slot 0, `sel` goes to 1, and the state goes to LOCKED.
- LOCKED state:
  - Each `en` cycle stores `din` into buffer slot `sel`.
  - `sel` increments and wraps from N-1 to 0.
- Frame completion: the `en` cycle that samples the last slot loads `q` from buffer slots 0..3 and pulses `frame_valid`.
- Missing sync (`sel==0` in LOCKED with `sync=0`):
  - The bit is still stored as slot 0 (flywheel) and the miss counter increments.
  - When the counter reaches `MISS_MAX`, the state goes to HUNT, `locked` goes to 0, and `sel` goes to 0.
  - No `frame_valid` is issued for that partial frame.
  - The counter clears on any correctly placed sync.
- Misplaced sync (`sync=1` with `sel!=0` in LOCKED):
  - `sync_err` pulses.
  - The partial frame is discarded with no `frame_valid`.
  - The bit is taken as slot 0 of a new frame, `sel` goes to 1, and the miss counter clears.
- `en=0`: no state change, and all pulse outputs return to 0.
- `q` holds its value between frames and across loss of lock.

## Timing
- All outputs are registered.
- `q`, `frame_valid` and `parity_err` change on the clock edge following the `en` cycle that samples the last slot. Latency from last-slot sample to output is 1 cycle.
- `sync_err` asserts on the edge after the offending sample and lasts exactly 1 cycle.
- `locked` rises on the edge after the first accepted sync. It falls on the edge after the `MISS_MAX`-th miss.
- Back-to-back frames are supported with `en` held high: one `frame_valid` every N cycles.
- `rst` overrides everything on the same edge, including mid-frame. A frame in progress is lost and `q` clears.

## Configuration
- `TDM_PARITY_EN` defined:
  - The frame is 5 slots and slot 4 carries even parity (XOR of slots 0..4 must be 0).
  - `sel` reaches 4.
  - On frame completion, `parity_err` pulses alongside `frame_valid` on a mismatch.
  - `q` is updated regardless of parity.
- `TDM_PARITY_EN` undefined:
  - The frame is 4 slots, `sel` never exceeds 3, and `parity_err` is constant 0.

## Test plan
- Lock and steer: reset, then `en=1`, and send `sync=1` with bits 1,0,0,0 followed by a second frame 0,1,1,0 (sync on first slot). Required: `locked=1` after the first sample; `q=4'b0001` then `q=4'b0110`; exactly one `frame_valid` pulse per frame, 1 cycle after slot 3.
- `en` gating: the same frame with `en` toggling 1,0,1,0. Required: `q` and `frame_valid` are the same as with continuous `en`; `sel` holds during `en=0`.
- Misplaced sync: `sync=1` at `sel=2`. Required: `sync_err` pulses once; no `frame_valid` for the partial frame; the next 3 bits plus the sync bit form the next `q`.
- Loss of lock (`MISS_MAX=2`): two frames with `sync=0` at slot 0. Required: the first frame is still delivered; `locked` drops after the second miss; HUNT ignores `din` until the next sync.
- Reset mid-frame: assert `rst` at `sel=2`. Required: all outputs return to their reset values on that edge, and the next sync relocks cleanly.
- `TDM_PARITY_EN`: frame 1,1,0,1 with parity 1 gives `q=4'b1011` and no error. The same frame with parity 0 gives `parity_err` pulsing together with `frame_valid`.
